// File: rtl/axi_sram_slave.sv
// AXI4 SRAM slave: independent write and read burst FSMs over a MEM_WORDS x 32-bit array.
// Define AXI_SRAM_WRAP_EN to enable WRAP bursts; otherwise every WRAP burst returns SLVERR.
//
// state  | meaning
// W_IDLE | awready high, waiting for a write address
// W_DATA | wready high, accepting beats until the counter reaches awlen
// W_RESP | bvalid high, holding the accumulated response until bready
// R_IDLE | arready high, waiting for a read address
// R_DATA | rvalid high, presenting the current beat until accepted
module axi_sram_slave #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready
);

    localparam int AW = $clog2(MEM_WORDS);
`ifdef AXI_SRAM_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    // Response codes are ordered by severity, so a numeric max merges them.
    function automatic logic [1:0] beat_resp(input logic [31:0] addr, input logic [2:0] size,
                                             input logic [1:0] burst, input logic [3:0] len);
        logic [1:0] resp;
        logic       len_ok;
        len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
        resp   = RESP_OKAY;
        if (size != 3'b010 || burst == 2'b11) resp = RESP_SLVERR;
        if (burst == 2'b10 && !(WRAP_EN && len_ok)) resp = RESP_SLVERR;
        if (addr[31:AW+2] != '0) resp = RESP_DECERR;
        return resp;
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst,
                                              input logic [3:0] len);
        logic [31:0] mask;
        mask = {26'd0, len, 2'b11};
        case (burst)
            2'b00:   next_addr = addr;
            2'b10:   next_addr = WRAP_EN ? ((addr & ~mask) | ((addr + 32'd4) & mask)) : addr + 32'd4;
            default: next_addr = addr + 32'd4;
        endcase
    endfunction

    logic [31:0] mem_q [MEM_WORDS];

    w_state_t    w_state_q, w_state_d;
    logic [3:0]  aw_id_q, aw_id_d, aw_len_q, aw_len_d, w_cnt_q, w_cnt_d;
    logic [31:0] aw_addr_q, aw_addr_d;
    logic [2:0]  aw_size_q, aw_size_d;
    logic [1:0]  aw_burst_q, aw_burst_d, bresp_q, bresp_d, w_beat_resp;
    logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d, mem_we;

    r_state_t    r_state_q, r_state_d;
    logic [3:0]  ar_id_q, ar_id_d, ar_len_q, ar_len_d, r_cnt_q, r_cnt_d;
    logic [31:0] ar_addr_q, ar_addr_d, rdata_q, rdata_d;
    logic [2:0]  ar_size_q, ar_size_d;
    logic [1:0]  ar_burst_q, ar_burst_d, rresp_q, rresp_d;
    logic        arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d, r_load;

    always_comb begin
        w_state_d   = w_state_q;
        aw_id_d     = aw_id_q;
        aw_addr_d   = aw_addr_q;
        aw_len_d    = aw_len_q;
        aw_size_d   = aw_size_q;
        aw_burst_d  = aw_burst_q;
        w_cnt_d     = w_cnt_q;
        bresp_d     = bresp_q;
        mem_we      = 1'b0;
        w_beat_resp = beat_resp(aw_addr_q, aw_size_q, aw_burst_q, aw_len_q);
        case (w_state_q)
            W_IDLE: if (awvalid && awready_q) begin
                w_state_d  = W_DATA;
                aw_id_d    = awid;
                aw_addr_d  = awaddr;
                aw_len_d   = awlen;
                aw_size_d  = awsize;
                aw_burst_d = awburst;
                w_cnt_d    = 4'd0;
                bresp_d    = RESP_OKAY;
            end
            W_DATA: if (wvalid && wready_q) begin
                mem_we  = (w_beat_resp == RESP_OKAY);
                bresp_d = (w_beat_resp > bresp_q) ? w_beat_resp : bresp_q;
                if (wlast != (w_cnt_q == aw_len_q) && bresp_d < RESP_SLVERR) bresp_d = RESP_SLVERR;
                if (w_cnt_q == aw_len_q) begin
                    w_state_d = W_RESP;
                end else begin
                    aw_addr_d = next_addr(aw_addr_q, aw_burst_q, aw_len_q);
                    w_cnt_d   = w_cnt_q + 4'd1;
                end
            end
            W_RESP: if (bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    // Beat data is fetched as the beat is loaded, so a same-cycle write is not yet visible.
    always_comb begin
        r_state_d  = r_state_q;
        ar_id_d    = ar_id_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_size_d  = ar_size_q;
        ar_burst_d = ar_burst_q;
        r_cnt_d    = r_cnt_q;
        rvalid_d   = rvalid_q;
        rlast_d    = rlast_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        r_load     = 1'b0;
        case (r_state_q)
            R_IDLE: if (arvalid && arready_q) begin
                r_state_d  = R_DATA;
                ar_id_d    = arid;
                ar_addr_d  = araddr;
                ar_len_d   = arlen;
                ar_size_d  = arsize;
                ar_burst_d = arburst;
                r_cnt_d    = 4'd0;
                rvalid_d   = 1'b1;
                rlast_d    = (arlen == 4'd0);
                r_load     = 1'b1;
            end
            R_DATA: if (rvalid_q && rready) begin
                if (rlast_q) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b0;
                    rlast_d   = 1'b0;
                end else begin
                    ar_addr_d = next_addr(ar_addr_q, ar_burst_q, ar_len_q);
                    r_cnt_d   = r_cnt_q + 4'd1;
                    rlast_d   = (r_cnt_d == ar_len_q);
                    r_load    = 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (r_load) begin
            rresp_d = beat_resp(ar_addr_d, ar_size_d, ar_burst_d, ar_len_d);
            rdata_d = (rresp_d == RESP_OKAY) ? mem_q[ar_addr_d[AW+1:2]] : 32'd0;
        end
        arready_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state_q  <= W_IDLE;
            aw_id_q    <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            w_cnt_q    <= '0;
            bresp_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            r_state_q  <= R_IDLE;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            r_cnt_q    <= '0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            rlast_q    <= 1'b0;
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            aw_id_q    <= aw_id_d;
            aw_addr_q  <= aw_addr_d;
            aw_len_q   <= aw_len_d;
            aw_size_q  <= aw_size_d;
            aw_burst_q <= aw_burst_d;
            w_cnt_q    <= w_cnt_d;
            bresp_q    <= bresp_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            r_state_q  <= r_state_d;
            ar_id_q    <= ar_id_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            ar_burst_q <= ar_burst_d;
            r_cnt_q    <= r_cnt_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rlast_q    <= rlast_d;
            rvalid_q   <= rvalid_d;
            arready_q  <= arready_d;
        end
    end

    // Storage is deliberately outside the reset domain so an aborted burst keeps prior data.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) mem_q[aw_addr_q[AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign bid     = aw_id_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign rid     = ar_id_q;

endmodule
